overlay_frame_buffer: RTL and testbench
=======================================

OVERLAY_FRAME_BUFFER -- requirements
Module: overlay_frame_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 480, active columns.
REQ-002 SHALL have parameter HEIGHT, default 640, active rows.
REQ-003 SHALL have parameter COLOR_W, default 4, bits per pixel; value 0 is transparent.
REQ-004 SHALL have parameter CNT_W, default 16, width of the status counters.
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 clk_in  input  1  system clock.
REQ-007 rst_n_in  input  1  synchronous active-low reset.
REQ-008 hcount_in  input  11  display read column.
REQ-009 vcount_in  input  10  display read row.
REQ-010 frame_sync_in  input  1  one-cycle pulse at display end-of-frame; requests a buffer swap.
REQ-011 wr_valid_in  input  1  draw-write request.
REQ-012 wr_x_in  input  11  draw column.
REQ-013 wr_y_in  input  10  draw row.
REQ-014 wr_color_in  input  COLOR_W  draw color.
REQ-015 wr_ready_out  output  1  draw write accepted this cycle.
REQ-016 hcount_out  output  11  hcount_in delayed to align with pixel_out.
REQ-017 vcount_out  output  10  vcount_in delayed to align with pixel_out.
REQ-018 pixel_out  output  COLOR_W  display pixel.
REQ-019 display_idx_out  output  2  index of the buffer now displayed.
REQ-020 clear_busy_out  output  1  clear engine running.
REQ-021 drop_count_out  output  CNT_W  count of dropped writes.
REQ-022 overrun_count_out  output  CNT_W  count of deferred swaps.

Function
REQ-023 SHALL hold 3 buffers of WIDTH*HEIGHT x COLOR_W; at any time exactly one has each role: DRAW, DISPLAY, CLEAR.
REQ-024 After reset, roles SHALL be DRAW=0, DISPLAY=1, CLEAR=2, and the clear engine SHALL start on buffer 2.
REQ-025 A write SHALL be accepted when wr_valid_in && wr_ready_out; wr_ready_out SHALL be 1 except during reset.
REQ-026 An accepted write SHALL go to the DRAW buffer at address wr_y_in*WIDTH+wr_x_in.
REQ-027 A write SHALL be committed only if wr_x_in<WIDTH, wr_y_in<HEIGHT and wr_color_in!=0.
REQ-028 An out-of-range accepted write SHALL increment drop_count_out; a transparent write SHALL be discarded silently.
REQ-029 Clear engine states: IDLE, CLEARING. On entry to CLEARING it SHALL write 0 to the CLEAR buffer at one address per cycle, from 0 to WIDTH*HEIGHT-1, then go to IDLE.
REQ-030 clear_busy_out SHALL be 1 exactly while the engine is in CLEARING.
REQ-031 Display read SHALL address the DISPLAY buffer at vcount_in*WIDTH+hcount_in, with pixel_out valid 2 cycles after the inputs.
REQ-032 hcount_out and vcount_out SHALL carry the same 2-cycle delay as pixel_out.
REQ-033 pixel_out SHALL be 0 when the delayed hcount>=WIDTH or delayed vcount>=HEIGHT.
REQ-034 Swap request: frame_sync_in SHALL set swap_pending.
REQ-035 The swap SHALL execute on the first cycle with swap_pending=1 and clear engine IDLE.
REQ-036 On a swap, roles SHALL rotate CLEAR->DRAW, DRAW->DISPLAY, DISPLAY->CLEAR, and the engine SHALL re-enter CLEARING on the next cycle.
REQ-037 A frame_sync_in that arrives while clear_busy_out=1 SHALL increment overrun_count_out once; the swap is deferred.
REQ-038 A frame_sync_in that arrives while a swap is already pending SHALL merge with it; no double rotation.
REQ-039 A write in the swap cycle SHALL land in the pre-swap DRAW buffer.
REQ-040 The read-buffer select SHALL be pipelined with the address, so in-flight pixels come from the pre-swap DISPLAY buffer.
REQ-041 Both counters SHALL saturate at all-ones.
REQ-042 All address arithmetic SHALL be $clog2(WIDTH*HEIGHT) bits wide with no truncation.

Reset
REQ-043 On rst_n_in=0 at a clock edge, all outputs SHALL be 0, except display_idx_out=1 and wr_ready_out=0.
REQ-044 Reset SHALL clear swap_pending and both counters, restore the roles of REQ-024, and restart the clear engine.
REQ-045 Reset asserted mid-clear or mid-swap SHALL abort the operation; buffer contents are not guaranteed until the first clear completes.

Structure
REQ-046 Package overlay_pkg SHALL hold the role enum (DRAW, DISPLAY, CLEAR), the clear-state enum, and a function for the next role rotation.
REQ-047 Each buffer SHALL be one instance of xilinx_true_dual_port_read_first_1_clock_ram in HIGH_PERFORMANCE mode.
REQ-048 Port A of each buffer SHALL serve draw-or-clear writes; port B SHALL serve display reads.

Verification
REQ-049 After reset, wait for clear_busy_out to fall (WIDTH*HEIGHT cycles), write (10,20,color 5), pulse frame_sync -> display_idx_out=0, and a read at (10,20) gives pixel_out=5 two cycles later.
REQ-050 Write (480,5,3) and (5,640,3) -> drop_count_out=2, no buffer contents change.
REQ-051 Write color 0 over an existing pixel of color 7 -> pixel remains 7, drop_count_out unchanged.
REQ-052 Pulse frame_sync while clear_busy_out=1 -> overrun_count_out increments by 1, display_idx_out unchanged until the clear ends, then rotates exactly once.
REQ-053 Pulse frame_sync twice per frame for 3 frames -> roles cycle 0,1,2 with no skipped buffer, and the old display buffer reads 0 after re-clear.
REQ-054 Assert reset for 1 cycle mid-clear -> outputs match REQ-043 and the clear restarts at address 0.

Source files
------------

// File: rtl/overlay_pkg.sv
// Shared types for the triple-buffered overlay: buffer roles, clear-engine states
// and the role rotation applied on every buffer swap.
package overlay_pkg;

    localparam int N_BUF = 3;

    typedef enum logic [1:0] {
        DRAW    = 2'd0,
        DISPLAY = 2'd1,
        CLEAR   = 2'd2
    } role_e;

    typedef enum logic {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } clr_state_e;

    // A swap rotates the roles: CLEAR -> DRAW -> DISPLAY -> CLEAR.
    function automatic role_e next_role(input role_e r);
        case (r)
            CLEAR:   next_role = DRAW;
            DRAW:    next_role = DISPLAY;
            default: next_role = CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/overlay_frame_buffer_if.sv
// Draw-write bus into the overlay frame buffer.
interface overlay_frame_buffer_if #(
    parameter int COLOR_W = 4
);
    logic               wr_valid_in;
    logic [10:0]        wr_x_in;
    logic [9:0]         wr_y_in;
    logic [COLOR_W-1:0] wr_color_in;
    logic               wr_ready_out;

    modport master (
        output wr_valid_in, wr_x_in, wr_y_in, wr_color_in,
        input  wr_ready_out
    );

    modport slave (
        input  wr_valid_in, wr_x_in, wr_y_in, wr_color_in,
        output wr_ready_out
    );
endinterface

// File: rtl/overlay_frame_buffer_ctrl.sv
// Role bookkeeping, swap arbitration, clear engine and status counters.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | no clear running; a pending swap (or post-reset start) may fire
//   CLEARING | writing 0 to the CLEAR buffer, one address per cycle
module overlay_frame_buffer_ctrl
    import overlay_pkg::*;
#(
    parameter int DEPTH  = 480 * 640,
    parameter int ADDR_W = $clog2(480 * 640),
    parameter int CNT_W  = 16
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              frame_sync_in,
    input  logic              drop_in,
    output logic [1:0]        draw_idx,
    output logic [1:0]        disp_idx,
    output logic [1:0]        clear_idx,
    output logic              clear_we,
    output logic [ADDR_W-1:0] clear_addr,
    output logic              clear_busy,
    output logic [CNT_W-1:0]  drop_count,
    output logic [CNT_W-1:0]  overrun_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              start_q;
    logic              swap_pending_q;
    logic              swap_fire;
    role_e             role_q [N_BUF];

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            start_q        <= 1'b1;
            swap_pending_q <= 1'b0;
            role_q[0]      <= DRAW;
            role_q[1]      <= DISPLAY;
            role_q[2]      <= CLEAR;
            drop_count     <= '0;
            overrun_count  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            if (state_q == IDLE) start_q <= 1'b0;
            // A sync arriving while a swap is already pending merges into it.
            swap_pending_q <= swap_fire ? 1'b0 : (swap_pending_q | frame_sync_in);
            if (swap_fire) begin
                for (int i = 0; i < N_BUF; i++) role_q[i] <= next_role(role_q[i]);
            end
            if (frame_sync_in && state_q == CLEARING && overrun_count != '1)
                overrun_count <= overrun_count + 1'b1;
            if (drop_in && drop_count != '1)
                drop_count <= drop_count + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        swap_fire = 1'b0;
        case (state_q)
            IDLE: begin
                // The post-reset clear takes priority so a swap never rotates
                // an uncleared buffer into DRAW.
                if (start_q) begin
                    state_d = CLEARING;
                    addr_d  = '0;
                end else if (swap_pending_q) begin
                    swap_fire = 1'b1;
                    state_d   = CLEARING;
                    addr_d    = '0;
                end
            end
            CLEARING: begin
                if (addr_q == LAST_ADDR) state_d = IDLE;
                else                     addr_d  = addr_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        draw_idx  = 2'd0;
        disp_idx  = 2'd1;
        clear_idx = 2'd2;
        for (int i = 0; i < N_BUF; i++) begin
            if (role_q[i] == DRAW)    draw_idx  = 2'(i);
            if (role_q[i] == DISPLAY) disp_idx  = 2'(i);
            if (role_q[i] == CLEAR)   clear_idx = 2'(i);
        end
    end

    assign clear_we   = (state_q == CLEARING);
    assign clear_busy = (state_q == CLEARING);
    assign clear_addr = addr_q;

endmodule

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// Single-clock true dual-port read-first RAM; HIGH_PERFORMANCE adds an output
// register, giving two cycles of read latency.
module xilinx_true_dual_port_read_first_1_clock_ram #(
    parameter int RAM_WIDTH       = 18,
    parameter int RAM_DEPTH       = 1024,
    parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic [RAM_WIDTH-1:0]         dinb,
    input  logic                         clka,
    input  logic                         wea,
    input  logic                         web,
    input  logic                         ena,
    input  logic                         enb,
    input  logic                         rsta,
    input  logic                         rstb,
    input  logic                         regcea,
    input  logic                         regceb,
    output logic [RAM_WIDTH-1:0]         douta,
    output logic [RAM_WIDTH-1:0]         doutb
);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data_a;
    logic [RAM_WIDTH-1:0] ram_data_b;

    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) mem[addra] <= dina;
            ram_data_a <= mem[addra];
        end
        if (enb) begin
            if (web) mem[addrb] <= dinb;
            ram_data_b <= mem[addrb];
        end
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_out_reg
            assign douta = ram_data_a;
            assign doutb = ram_data_b;
        end else begin : g_out_reg
            logic [RAM_WIDTH-1:0] douta_reg;
            logic [RAM_WIDTH-1:0] doutb_reg;

            always_ff @(posedge clka) begin
                if (rsta)        douta_reg <= '0;
                else if (regcea) douta_reg <= ram_data_a;
                if (rstb)        doutb_reg <= '0;
                else if (regceb) doutb_reg <= ram_data_b;
            end

            assign douta = douta_reg;
            assign doutb = doutb_reg;
        end
    endgenerate

endmodule

// File: rtl/overlay_frame_buffer.sv
// Triple-buffered overlay: draw writes, background clear and display reads each
// own one buffer; roles rotate on frame sync once the clear engine is idle.
module overlay_frame_buffer
    import overlay_pkg::*;
#(
    parameter int WIDTH   = 480,
    parameter int HEIGHT  = 640,
    parameter int COLOR_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [10:0]          hcount_in,
    input  logic [9:0]           vcount_in,
    input  logic                 frame_sync_in,
    overlay_frame_buffer_if.slave wr_bus,
    output logic [10:0]          hcount_out,
    output logic [9:0]           vcount_out,
    output logic [COLOR_W-1:0]   pixel_out,
    output logic [1:0]           display_idx_out,
    output logic                 clear_busy_out,
    output logic [CNT_W-1:0]     drop_count_out,
    output logic [CNT_W-1:0]     overrun_count_out
);

    localparam int          DEPTH    = WIDTH * HEIGHT;
    localparam int          ADDR_W   = $clog2(DEPTH);
    localparam logic [31:0] WIDTH_U  = 32'(WIDTH);
    localparam logic [31:0] HEIGHT_U = 32'(HEIGHT);

    logic               ready_q;
    logic               wr_accept, wr_in_range, wr_commit, wr_drop;
    logic [ADDR_W-1:0]  wr_addr, rd_addr, clear_addr;
    logic [1:0]         draw_idx, disp_idx, clear_idx;
    logic               clear_we;
    logic [1:0]         sel_d1, sel_d2;
    logic [10:0]        h_d1, h_d2;
    logic [9:0]         v_d1, v_d2;
    logic [COLOR_W-1:0] rd_data [N_BUF];
    logic [COLOR_W-1:0] rd_pix;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) ready_q <= 1'b0;
        else           ready_q <= 1'b1;
    end

    assign wr_bus.wr_ready_out = ready_q;
    assign wr_accept   = wr_bus.wr_valid_in && ready_q;
    assign wr_in_range = (32'(wr_bus.wr_x_in) < WIDTH_U) && (32'(wr_bus.wr_y_in) < HEIGHT_U);
    assign wr_commit   = wr_accept && wr_in_range && (wr_bus.wr_color_in != '0);
    assign wr_drop     = wr_accept && !wr_in_range;
    assign wr_addr     = ADDR_W'(wr_bus.wr_y_in) * ADDR_W'(WIDTH) + ADDR_W'(wr_bus.wr_x_in);
    assign rd_addr     = ADDR_W'(vcount_in) * ADDR_W'(WIDTH) + ADDR_W'(hcount_in);

    overlay_frame_buffer_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_ctrl (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .frame_sync_in (frame_sync_in),
        .drop_in       (wr_drop),
        .draw_idx      (draw_idx),
        .disp_idx      (disp_idx),
        .clear_idx     (clear_idx),
        .clear_we      (clear_we),
        .clear_addr    (clear_addr),
        .clear_busy    (clear_busy_out),
        .drop_count    (drop_count_out),
        .overrun_count (overrun_count_out)
    );

    for (genvar b = 0; b < N_BUF; b++) begin : g_buf
        logic               we_a;
        logic [ADDR_W-1:0]  addr_a;
        logic [COLOR_W-1:0] din_a;
        logic [COLOR_W-1:0] unused_douta;

        // DRAW and CLEAR are always distinct buffers, so port A never sees both.
        always_comb begin
            we_a   = 1'b0;
            addr_a = wr_addr;
            din_a  = wr_bus.wr_color_in;
            if (clear_we && clear_idx == 2'(b)) begin
                we_a   = 1'b1;
                addr_a = clear_addr;
                din_a  = '0;
            end else if (wr_commit && draw_idx == 2'(b)) begin
                we_a = 1'b1;
            end
        end

        xilinx_true_dual_port_read_first_1_clock_ram #(
            .RAM_WIDTH       (COLOR_W),
            .RAM_DEPTH       (DEPTH),
            .RAM_PERFORMANCE ("HIGH_PERFORMANCE")
        ) u_ram (
            .addra  (addr_a),
            .addrb  (rd_addr),
            .dina   (din_a),
            .dinb   ('0),
            .clka   (clk_in),
            .wea    (we_a),
            .web    (1'b0),
            .ena    (1'b1),
            .enb    (1'b1),
            .rsta   (~rst_n_in),
            .rstb   (~rst_n_in),
            .regcea (1'b1),
            .regceb (1'b1),
            .douta  (unused_douta),
            .doutb  (rd_data[b])
        );
    end

    // Buffer select travels with the read address so pixels in flight across a
    // swap still come from the buffer they were addressed in.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            sel_d1 <= 2'd1;
            sel_d2 <= 2'd1;
            h_d1   <= '0;
            h_d2   <= '0;
            v_d1   <= '0;
            v_d2   <= '0;
        end else begin
            sel_d1 <= disp_idx;
            sel_d2 <= sel_d1;
            h_d1   <= hcount_in;
            h_d2   <= h_d1;
            v_d1   <= vcount_in;
            v_d2   <= v_d1;
        end
    end

    always_comb begin
        rd_pix = '0;
        case (sel_d2)
            2'd0:    rd_pix = rd_data[0];
            2'd1:    rd_pix = rd_data[1];
            2'd2:    rd_pix = rd_data[2];
            default: rd_pix = '0;
        endcase
    end

    assign pixel_out       = ((32'(h_d2) < WIDTH_U) && (32'(v_d2) < HEIGHT_U)) ? rd_pix : '0;
    assign hcount_out      = h_d2;
    assign vcount_out      = v_d2;
    assign display_idx_out = disp_idx;

endmodule

// File: tb/tb_overlay_frame_buffer.sv
// Directed bench for overlay_frame_buffer on a 16x8 frame with 2-bit counters.
module tb_overlay_frame_buffer;

    localparam int W = 16;
    localparam int H = 8;
    localparam int N = W * H;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        frame_sync_in;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic [3:0]  pixel_out;
    logic [1:0]  display_idx_out;
    logic        clear_busy_out;
    logic [1:0]  drop_count_out;
    logic [1:0]  overrun_count_out;

    int checks = 0;
    int errors = 0;
    int n;

    overlay_frame_buffer_if #(.COLOR_W(4)) wr_if ();

    overlay_frame_buffer #(
        .WIDTH   (W),
        .HEIGHT  (H),
        .COLOR_W (4),
        .CNT_W   (2)
    ) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .hcount_in         (hcount_in),
        .vcount_in         (vcount_in),
        .frame_sync_in     (frame_sync_in),
        .wr_bus            (wr_if),
        .hcount_out        (hcount_out),
        .vcount_out        (vcount_out),
        .pixel_out         (pixel_out),
        .display_idx_out   (display_idx_out),
        .clear_busy_out    (clear_busy_out),
        .drop_count_out    (drop_count_out),
        .overrun_count_out (overrun_count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int x, input int y, input int c);
        wr_if.wr_valid_in = 1'b1;
        wr_if.wr_x_in     = 11'(x);
        wr_if.wr_y_in     = 10'(y);
        wr_if.wr_color_in = 4'(c);
        tick();
        wr_if.wr_valid_in = 1'b0;
    endtask

    task automatic rd(input string tag, input int x, input int y, input int exp);
        hcount_in = 11'(x);
        vcount_in = 10'(y);
        tick();
        tick();
        check(tag, 32'(pixel_out), exp);
    endtask

    task automatic sync_pulse();
        frame_sync_in = 1'b1;
        tick();
        frame_sync_in = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (clear_busy_out && cyc < 400) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        rst_n_in          = 1'b0;
        hcount_in         = 11'd5;
        vcount_in         = 10'd3;
        frame_sync_in     = 1'b0;
        wr_if.wr_valid_in = 1'b0;
        wr_if.wr_x_in     = '0;
        wr_if.wr_y_in     = '0;
        wr_if.wr_color_in = '0;
        tick();
        tick();

        // reset state
        check("rst_ready",   32'(wr_if.wr_ready_out), 0);
        check("rst_disp",    32'(display_idx_out), 1);
        check("rst_busy",    32'(clear_busy_out), 0);
        check("rst_pixel",   32'(pixel_out), 0);
        check("rst_hcount",  32'(hcount_out), 0);
        check("rst_vcount",  32'(vcount_out), 0);
        check("rst_drop",    32'(drop_count_out), 0);
        check("rst_overrun", 32'(overrun_count_out), 0);

        // initial clear of buffer 2 lasts exactly N cycles
        rst_n_in = 1'b1;
        tick();
        check("ready_after_rst", 32'(wr_if.wr_ready_out), 1);
        check("busy_after_rst",  32'(clear_busy_out), 1);
        wait_idle(n);
        check("init_clear_len", n, N);

        // phase A: draw into buffer 0
        wr(10, 5, 5);
        wr(3, 2, 7);
        wr(15, 7, 4);
        wr(3, 2, 0);
        check("transparent_no_drop", 32'(drop_count_out), 0);
        sync_pulse();
        tick();
        check("swap1_disp", 32'(display_idx_out), 0);
        check("swap1_busy", 32'(clear_busy_out), 1);

        // phase B: display 0, draw 2, clear 1
        rd("pix_10_5", 10, 5, 5);
        check("hcount_align", 32'(hcount_out), 10);
        check("vcount_align", 32'(vcount_out), 5);
        rd("pix_transparent_kept", 3, 2, 7);
        rd("pix_last_addr", 15, 7, 4);
        rd("pix_h_oob_masked", 90, 0, 0);
        rd("pix_v_oob_masked", 35, 8, 0);
        sync_pulse();
        sync_pulse();
        check("overrun_two", 32'(overrun_count_out), 2);
        check("disp_deferred", 32'(display_idx_out), 0);
        wr(W, 5, 3);
        wr(5, H, 3);
        check("drop_two", 32'(drop_count_out), 2);
        wr(2, 3, 11);
        wait_idle(n);
        check("b_clear_done", 32'(clear_busy_out), 0);
        check("b_disp_before_swap", 32'(display_idx_out), 0);
        wr(1, 1, 6);
        check("swap2_disp", 32'(display_idx_out), 2);
        check("swap2_busy", 32'(clear_busy_out), 1);

        // phase C: display 2, draw 1, clear 0
        rd("pix_2_3", 2, 3, 11);
        rd("pix_swap_cycle_write", 1, 1, 6);
        rd("drop_no_commit_a", 0, 6, 0);
        rd("drop_no_commit_b", 5, 0, 0);
        wr(4, 4, 13);
        wait_idle(n);
        check("c_clear_done", 32'(clear_busy_out), 0);
        tick();
        tick();
        tick();
        check("no_double_rotate", 32'(display_idx_out), 2);
        check("idle_not_busy", 32'(clear_busy_out), 0);

        // phase D: display 1, draw 0, clear 2
        sync_pulse();
        tick();
        check("swap3_disp", 32'(display_idx_out), 1);
        rd("pix_4_4", 4, 4, 13);
        sync_pulse();
        sync_pulse();
        check("overrun_saturate", 32'(overrun_count_out), 3);
        wr(W, 0, 1);
        wr(0, H + 1, 1);
        check("drop_saturate", 32'(drop_count_out), 3);
        wait_idle(n);
        check("d_clear_done", 32'(clear_busy_out), 0);
        check("d_disp_before_swap", 32'(display_idx_out), 1);
        tick();
        check("swap4_disp", 32'(display_idx_out), 0);

        // phase E: buffer 0 was re-cleared while it held the CLEAR role
        rd("recleared_10_5", 10, 5, 0);
        rd("recleared_3_2", 3, 2, 0);
        rd("recleared_0_1", 0, 1, 0);

        // reset in the middle of a clear
        tick();
        tick();
        rst_n_in = 1'b0;
        tick();
        check("mid_rst_ready",   32'(wr_if.wr_ready_out), 0);
        check("mid_rst_disp",    32'(display_idx_out), 1);
        check("mid_rst_busy",    32'(clear_busy_out), 0);
        check("mid_rst_pixel",   32'(pixel_out), 0);
        check("mid_rst_hcount",  32'(hcount_out), 0);
        check("mid_rst_drop",    32'(drop_count_out), 0);
        check("mid_rst_overrun", 32'(overrun_count_out), 0);
        rst_n_in = 1'b1;
        tick();
        check("restart_busy", 32'(clear_busy_out), 1);
        wait_idle(n);
        check("restart_clear_len", n, N);
        check("restart_disp", 32'(display_idx_out), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
